// File: rtl/exc_ctrl_if.sv
// Signal bundle between the MEM stage / CP0 side and the exception controller.
// The controller uses the slave modport; the pipeline side uses master.
interface exc_ctrl_if;
  logic        mem_valid_i;
  logic        mem_stall_i;
  logic [31:0] mem_pc_i;
  logic        mem_dslot_i;
  logic [8:0]  exc_flags_i;
  logic [31:0] mem_daddr_i;
  logic [5:0]  int_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic        cp0_we_i;
  logic [31:0] excepttype_o;
  logic [31:0] epc_pc_o;
  logic        dslot_o;
  logic [31:0] bad_addr_o;
  logic [5:0]  int_sync_o;
  logic        flush_o;
  logic        redirect_o;
  logic [31:0] new_pc_o;

  modport slave (
    input  mem_valid_i, mem_stall_i, mem_pc_i, mem_dslot_i, exc_flags_i, mem_daddr_i,
           int_i, cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_we_i,
    output excepttype_o, epc_pc_o, dslot_o, bad_addr_o, int_sync_o, flush_o,
           redirect_o, new_pc_o
  );

  modport master (
    output mem_valid_i, mem_stall_i, mem_pc_i, mem_dslot_i, exc_flags_i, mem_daddr_i,
           int_i, cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_we_i,
    input  excepttype_o, epc_pc_o, dslot_o, bad_addr_o, int_sync_o, flush_o,
           redirect_o, new_pc_o
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt scheduler: picks the highest-priority MEM-stage event, reports it
// to CP0 for one cycle, then holds the pipeline flush while the PC is redirected.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  exc_ctrl_if.slave  bus
);
  localparam int unsigned   CW       = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [5:0]    r_int_meta, r_int_sync;
  logic [31:0]   r_excepttype, r_epc_pc, r_bad_addr, r_new_pc;
  logic          r_dslot, r_redirect;

  logic          w_int_pend, w_take, w_bad_we, w_is_eret;
  logic [4:0]    w_code;
  logic [31:0]   w_bad_val;
  logic [8:0]    w_flags;
  logic          w_unused;

  assign w_flags  = bus.exc_flags_i;
  assign w_unused = ^{bus.cp0_status_i[31:16], bus.cp0_status_i[7:2],
                      bus.cp0_cause_i[31:10], bus.cp0_cause_i[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int_meta <= '0;
      r_int_sync <= '0;
    end else begin
      r_int_meta <= bus.int_i;
      r_int_sync <= r_int_meta;
    end
  end

  // A CP0 write this cycle hides interrupts so the new Status/Cause takes effect first.
  assign w_int_pend = bus.cp0_status_i[0] & ~bus.cp0_status_i[1] &
                      (|(bus.cp0_status_i[15:8] & {r_int_sync, bus.cp0_cause_i[9:8]})) &
                      ~bus.cp0_we_i;

  assign w_take = (r_state == IDLE) & bus.mem_valid_i & ~bus.mem_stall_i &
                  (w_int_pend | (|w_flags));

  // Flag order: {eret,ades,adel_d,trap,ov,brk,sys,ri,adel_if}
  always_comb begin
    w_code    = 5'h00;
    w_bad_we  = 1'b0;
    w_bad_val = bus.mem_daddr_i;
    w_is_eret = 1'b0;
    if (w_int_pend) begin
      w_code = 5'h01;
    end else if (w_flags[0]) begin
      w_code    = 5'h04;
      w_bad_we  = 1'b1;
      w_bad_val = bus.mem_pc_i;
    end else if (w_flags[1]) begin
      w_code = 5'h0a;
    end else if (w_flags[2]) begin
      w_code = 5'h08;
    end else if (w_flags[3]) begin
      w_code = 5'h09;
    end else if (w_flags[4]) begin
      w_code = 5'h0c;
    end else if (w_flags[5]) begin
      w_code = 5'h0d;
    end else if (w_flags[6]) begin
      w_code   = 5'h04;
      w_bad_we = 1'b1;
    end else if (w_flags[7]) begin
      w_code   = 5'h05;
      w_bad_we = 1'b1;
    end else if (w_flags[8]) begin
      w_code    = 5'h0e;
      w_is_eret = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_take) begin
          w_state_next = FLUSH;
          w_cnt_next   = CNT_LOAD;
        end
      end
      FLUSH: begin
        if (r_cnt == '0) w_state_next = IDLE;
        else             w_cnt_next   = r_cnt - CW'(1);
      end
      default: w_state_next = IDLE;
    endcase
  end

  // EPC, dslot, BadVAddr and redirect target hold until the next event overwrites them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_excepttype <= '0;
      r_epc_pc     <= '0;
      r_dslot      <= 1'b0;
      r_bad_addr   <= '0;
      r_new_pc     <= '0;
      r_redirect   <= 1'b0;
    end else begin
      r_redirect   <= w_take;
      r_excepttype <= w_take ? {27'd0, w_code} : 32'd0;
      if (w_take) begin
        r_epc_pc <= bus.mem_pc_i;
        r_dslot  <= bus.mem_dslot_i;
        r_new_pc <= w_is_eret ? bus.cp0_epc_i : EXC_VECTOR;
        if (w_bad_we) r_bad_addr <= w_bad_val;
      end
    end
  end

  assign bus.excepttype_o = r_excepttype;
  assign bus.epc_pc_o     = r_epc_pc;
  assign bus.dslot_o      = r_dslot;
  assign bus.bad_addr_o   = r_bad_addr;
  assign bus.int_sync_o   = r_int_sync;
  assign bus.flush_o      = (r_state == FLUSH);
  assign bus.redirect_o   = r_redirect;
  assign bus.new_pc_o     = r_new_pc;
endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: table of single events plus hand sequences for interrupts,
// held flags, stalls and reset during flush; redirects are checked against a scoreboard.
module tb_exc_ctrl;
  localparam logic [31:0] VEC = 32'hBFC00380;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exc_ctrl_if bus ();

  exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [8:0]  flags;
    logic [31:0] pc;
    logic        dslot;
    logic [31:0] daddr;
    logic [31:0] epc;
    logic [4:0]  code;
    logic [31:0] bad;
    logic [31:0] npc;
  } vec_t;

  typedef struct {
    logic [4:0]  code;
    logic [31:0] epc;
    logic        dslot;
    logic [31:0] bad;
    logic [31:0] npc;
  } exp_t;

  vec_t vt[12];
  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_redir = 0;
  int   base;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: every redirect pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.redirect_o) begin
      n_redir++;
      $display("[TB] event code=0x%02h epc=0x%08h dslot=%0d bad=0x%08h new_pc=0x%08h",
               bus.excepttype_o, bus.epc_pc_o, bus.dslot_o, bus.bad_addr_o, bus.new_pc_o);
      if (sb_q.size() == 0) begin
        check("unexpected_redirect", bus.excepttype_o, 32'h0);
      end else begin
        e = sb_q.pop_front();
        check("excepttype", bus.excepttype_o, {27'd0, e.code});
        check("epc_pc", bus.epc_pc_o, e.epc);
        check("dslot", 32'(bus.dslot_o), 32'(e.dslot));
        check("bad_addr", bus.bad_addr_o, e.bad);
        check("new_pc", bus.new_pc_o, e.npc);
      end
    end
  end

  task automatic idle_inputs();
    bus.mem_valid_i = 1'b0;
    bus.mem_stall_i = 1'b0;
    bus.exc_flags_i = '0;
    bus.mem_dslot_i = 1'b0;
    bus.cp0_we_i    = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at the first negedge it is idle again.
  task automatic run_event(input vec_t v);
    exp_t e;
    bus.mem_valid_i  = 1'b1;
    bus.exc_flags_i  = v.flags;
    bus.mem_pc_i     = v.pc;
    bus.mem_dslot_i  = v.dslot;
    bus.mem_daddr_i  = v.daddr;
    bus.cp0_epc_i    = v.epc;
    e = '{v.code, v.pc, v.dslot, v.bad, v.npc};
    sb_q.push_back(e);
    @(negedge clk);
    idle_inputs();
    check("flush_cycle1", 32'(bus.flush_o), 32'd1);
    @(negedge clk);
    check("flush_cycle2", 32'(bus.flush_o), 32'd1);
    check("redirect_pulse_end", 32'(bus.redirect_o), 32'd0);
    check("excepttype_pulse_end", bus.excepttype_o, 32'h0);
    @(negedge clk);
    check("flush_drop", 32'(bus.flush_o), 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    exp_t e;
    vt[0]  = '{9'h004, 32'h80001000, 1'b0, 32'h00000000, 32'h0,        5'h08, 32'h00000000, VEC};
    vt[1]  = '{9'h010, 32'h80000204, 1'b1, 32'h00000000, 32'h0,        5'h0c, 32'h00000000, VEC};
    vt[2]  = '{9'h040, 32'h80000300, 1'b0, 32'h00000003, 32'h0,        5'h04, 32'h00000003, VEC};
    vt[3]  = '{9'h003, 32'h80000002, 1'b0, 32'h00001234, 32'h0,        5'h04, 32'h80000002, VEC};
    vt[4]  = '{9'h100, 32'h80000500, 1'b0, 32'h00000000, 32'h80000400, 5'h0e, 32'h80000002, 32'h80000400};
    vt[5]  = '{9'h008, 32'h80000600, 1'b1, 32'h00000000, 32'h0,        5'h09, 32'h80000002, VEC};
    vt[6]  = '{9'h020, 32'h80000604, 1'b0, 32'h00000000, 32'h0,        5'h0d, 32'h80000002, VEC};
    vt[7]  = '{9'h080, 32'h80000608, 1'b0, 32'h10000001, 32'h0,        5'h05, 32'h10000001, VEC};
    vt[8]  = '{9'h006, 32'h8000060c, 1'b0, 32'h00000000, 32'h0,        5'h0a, 32'h10000001, VEC};
    vt[9]  = '{9'h0c0, 32'h80000610, 1'b0, 32'h00000022, 32'h0,        5'h04, 32'h00000022, VEC};
    vt[10] = '{9'h030, 32'h80000614, 1'b1, 32'h00000000, 32'h0,        5'h0c, 32'h00000022, VEC};
    vt[11] = '{9'h104, 32'h80000618, 1'b0, 32'h00000000, 32'h80000700, 5'h08, 32'h00000022, VEC};

    idle_inputs();
    bus.mem_pc_i     = '0;
    bus.mem_daddr_i  = '0;
    bus.int_i        = '0;
    bus.cp0_status_i = '0;
    bus.cp0_cause_i  = '0;
    bus.cp0_epc_i    = '0;

    repeat (3) @(negedge clk);
    check("rst_excepttype", bus.excepttype_o, 32'h0);
    check("rst_epc", bus.epc_pc_o, 32'h0);
    check("rst_bad", bus.bad_addr_o, 32'h0);
    check("rst_new_pc", bus.new_pc_o, 32'h0);
    check("rst_ctrl", {26'd0, bus.flush_o, bus.redirect_o, bus.dslot_o, 3'd0}, 32'h0);
    check("rst_int_sync", 32'(bus.int_sync_o), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_event(vt[i]);

    // Stalled or invalid MEM stage takes nothing.
    base = n_redir;
    bus.exc_flags_i = 9'h004;
    bus.mem_valid_i = 1'b1;
    bus.mem_stall_i = 1'b1;
    repeat (4) @(negedge clk);
    bus.mem_stall_i = 1'b0;
    bus.mem_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    idle_inputs();
    check("stall_invalid_no_take", 32'(n_redir - base), 32'd0);
    check("stall_flush_low", 32'(bus.flush_o), 32'd0);

    // Flags held through FLUSH: second take only once flush has dropped.
    base = n_redir;
    e = '{5'h08, 32'h80000a00, 1'b0, 32'h22, VEC};
    bus.mem_pc_i    = 32'h80000a00;
    bus.exc_flags_i = 9'h004;
    bus.mem_valid_i = 1'b1;
    sb_q.push_back(e);
    sb_q.push_back(e);
    @(negedge clk);
    check("held_flush1", 32'(bus.flush_o), 32'd1);
    @(negedge clk);
    check("held_flush2", 32'(bus.flush_o), 32'd1);
    @(negedge clk);
    check("held_idle_gap", 32'(bus.flush_o), 32'd0);
    @(negedge clk);
    check("held_retake", 32'(bus.redirect_o), 32'd1);
    repeat (2) @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    check("held_two_events", 32'(n_redir - base), 32'd2);
    check("held_sb_drained", 32'(sb_q.size()), 32'd0);

    // Interrupt line 0 through the synchroniser.
    bus.int_i = 6'b000001;
    @(negedge clk);
    check("int_sync_stage1", 32'(bus.int_sync_o), 32'd0);
    @(negedge clk);
    check("int_sync_stage2", 32'(bus.int_sync_o), 32'd1);

    // EXL set masks the interrupt.
    base = n_redir;
    bus.cp0_status_i = 32'h00000403;
    bus.mem_valid_i  = 1'b1;
    bus.mem_pc_i     = 32'h80000800;
    repeat (3) @(negedge clk);
    check("exl_masks_int", 32'(n_redir - base), 32'd0);

    // CP0 write on the first eligible cycle defers the interrupt by one cycle.
    bus.cp0_status_i = 32'h00000401;
    bus.cp0_we_i     = 1'b1;
    @(negedge clk);
    check("cp0_we_defers", 32'(bus.redirect_o), 32'd0);
    bus.cp0_we_i = 1'b0;
    e = '{5'h01, 32'h80000800, 1'b0, 32'h22, VEC};
    sb_q.push_back(e);
    @(negedge clk);
    check("int_taken_next", 32'(bus.redirect_o), 32'd1);
    bus.mem_valid_i = 1'b0;
    repeat (2) @(negedge clk);

    // Interrupt and sys in the same cycle: interrupt wins.
    bus.mem_valid_i = 1'b1;
    bus.exc_flags_i = 9'h004;
    bus.mem_pc_i    = 32'h80000900;
    e = '{5'h01, 32'h80000900, 1'b0, 32'h22, VEC};
    sb_q.push_back(e);
    @(negedge clk);
    idle_inputs();
    bus.int_i        = '0;
    bus.cp0_status_i = '0;
    repeat (3) @(negedge clk);
    check("int_sb_drained", 32'(sb_q.size()), 32'd0);

    // Reset during FLUSH clears flush_o at once, without waiting for a clock edge.
    bus.mem_valid_i = 1'b1;
    bus.exc_flags_i = 9'h004;
    bus.mem_pc_i    = 32'h80000b00;
    e = '{5'h08, 32'h80000b00, 1'b0, 32'h22, VEC};
    sb_q.push_back(e);
    @(negedge clk);
    idle_inputs();
    check("pre_rst_flush", 32'(bus.flush_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_flush", 32'(bus.flush_o), 32'd0);
    check("async_rst_redirect", 32'(bus.redirect_o), 32'd0);
    check("async_rst_new_pc", bus.new_pc_o, 32'h0);
    check("async_rst_bad", bus.bad_addr_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_event('{9'h008, 32'h80000c00, 1'b0, 32'h0, 32'h0, 5'h09, 32'h00000000, VEC});

    check("final_sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
